stopwatch_counter: RTL and testbench

- Counts elapsed time as minutes:seconds in four BCD digits, 00:00 to 59:59.
- Sits directly downstream of the clock divider and consumes its clk_1hz and clk_2hz square waves as same-domain enable sources.
- Supports run/pause, clear, and a per-field adjust mode.
- Its digit outputs feed the seven-segment display driver.

---
 rtl/stopwatch_counter.sv | 100 ++++++++++
 tb/tb_stopwatch_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch held as four BCD digits. Advances on rising edges of the
// divider's 1 Hz wave in run mode, or bumps one field on 2 Hz edges in adjust mode.
module stopwatch_counter #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       pause,
    input  logic       clr,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       wrap
);

    localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);
    localparam logic [3:0] SEC_T_MAX = 4'(MAX_SEC / 10);
    localparam logic [3:0] SEC_O_MAX = 4'(MAX_SEC % 10);

    // Next BCD value of a tens/ones pair: 9 carries into tens, max rolls to 00.
    function automatic logic [7:0] bump(input logic [3:0] t, input logic [3:0] o,
                                        input logic [3:0] tmax, input logic [3:0] omax);
        if (t == tmax && o == omax)
            return 8'h00;
        else if (o == 4'd9)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    logic       p1;
    logic       p2;
    logic       e1;
    logic       e2;
    logic       run_inc;
    logic       adj_inc;
    logic       sec_at_max;
    logic       min_at_max;
    logic [7:0] sec_next;
    logic [7:0] min_next;

    always_comb begin
        e1         = clk_1hz & ~p1;
        e2         = clk_2hz & ~p2;
        run_inc    = ~adj & e1 & ~paused;
        adj_inc    = adj & e2;
        sec_at_max = (sec_tens == SEC_T_MAX) && (sec_ones == SEC_O_MAX);
        min_at_max = (min_tens == MIN_T_MAX) && (min_ones == MIN_O_MAX);
        sec_next   = bump(sec_tens, sec_ones, SEC_T_MAX, SEC_O_MAX);
        min_next   = bump(min_tens, min_ones, MIN_T_MAX, MIN_O_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1       <= 1'b0;
            p2       <= 1'b0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            paused   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            // Edge history tracks the inputs in every mode so no stale edge survives a mode change.
            p1   <= clk_1hz;
            p2   <= clk_2hz;
            wrap <= 1'b0;
            if (pause)
                paused <= ~paused;
            if (clr) begin
                min_tens <= 4'd0;
                min_ones <= 4'd0;
                sec_tens <= 4'd0;
                sec_ones <= 4'd0;
            end else if (run_inc) begin
                {sec_tens, sec_ones} <= sec_next;
                if (sec_at_max) begin
                    {min_tens, min_ones} <= min_next;
                    if (min_at_max)
                        wrap <= 1'b1;
                end
            end else if (adj_inc) begin
                // Adjust bumps a single field with no carry between fields.
                if (sel)
                    {sec_tens, sec_ones} <= sec_next;
                else
                    {min_tens, min_ones} <= min_next;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: a per-cycle vector table followed by
// hand-written sequences for rollover, pause, adjust, clear and reset cases.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_1hz;
    logic       clk_2hz;
    logic       pause;
    logic       clr;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    int wrap_cnt = 0;

    stopwatch_counter #(.MAX_MIN(59), .MAX_SEC(59)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_1hz  (clk_1hz),
        .clk_2hz  (clk_2hz),
        .pause    (pause),
        .clr      (clr),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .paused   (paused),
        .wrap     (wrap)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (wrap === 1'b1) wrap_cnt++;
    end

    // Time shown as BCD packed into 16 bits, so 16'h1234 reads as 12:34.
    function automatic logic [15:0] shown();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] t, input logic p, input logic w);
        check({name, " time"}, shown(), t);
        check({name, " paused"}, {15'd0, paused}, {15'd0, p});
        check({name, " wrap"}, {15'd0, wrap}, {15'd0, w});
    endtask

    // driver: called at a negedge; drives for one posedge and returns at the next negedge
    task automatic apply(input logic a, input logic s, input logic c1, input logic c2,
                         input logic pz, input logic cl);
        adj = a; sel = s; clk_1hz = c1; clk_2hz = c2; pause = pz; clr = cl;
        @(negedge clk);
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic adj_edges(input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, s, 1'b0, 1'b1, 1'b0, 1'b0);
            apply(1'b1, s, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; adj = 0; sel = 0; clk_1hz = 0; clk_2hz = 0; pause = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        adj;
        logic        sel;
        logic        c1;
        logic        c2;
        logic        pause;
        logic        clr;
        logic [15:0] exp_time;
        logic        exp_paused;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[23];
    int   w0;

    initial begin
        //             adj sel c1 c2 pz clr time     p  w
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0001,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0002,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0002,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0002,1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0002,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0002,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,16'h0003,1'b1,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0003,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0004,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0004,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,16'h0104,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0104,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0204,1'b1,1'b0};
        vecs[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0204,1'b1,1'b0};
        vecs[17] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0205,1'b1,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0205,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0001,1'b0,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,1'b0,1'b0};

        do_reset();
        @(negedge clk);
        check_state("reset", 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].adj, vecs[i].sel, vecs[i].c1, vecs[i].c2, vecs[i].pause, vecs[i].clr);
            check_state($sformatf("vec%0d", i), vecs[i].exp_time, vecs[i].exp_paused, vecs[i].exp_wrap);
        end

        // Full hour in run mode and the single-cycle wrap pulse.
        do_reset();
        @(negedge clk);
        w0 = wrap_cnt;
        run_edges(60);
        check("run 60", shown(), 16'h0100);
        run_edges(3539);
        check("run 5959", shown(), 16'h5959);
        check("no early wrap", 16'(wrap_cnt - w0), 16'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("rollover", 16'h0000, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap drops", {15'd0, wrap}, 16'd0);
        check("wrap once", 16'(wrap_cnt - w0), 16'd1);

        // Pause holds the count; resume continues.
        do_reset();
        @(negedge clk);
        run_edges(5);
        check("pre pause", shown(), 16'h0005);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_edges(10);
        check_state("paused hold", 16'h0005, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_edges(2);
        check_state("resumed", 16'h0007, 1'b0, 1'b0);

        // Adjust wraps per field with no carry and no wrap pulse.
        do_reset();
        @(negedge clk);
        w0 = wrap_cnt;
        adj_edges(1'b1, 58);
        check("adj preset", shown(), 16'h0058);
        adj_edges(1'b1, 3);
        check("adj sec wrap", shown(), 16'h0001);
        adj_edges(1'b0, 59);
        check("adj min 59", shown(), 16'h5901);
        adj_edges(1'b0, 1);
        check("adj min wrap", shown(), 16'h0001);
        check("adj no wrap", 16'(wrap_cnt - w0), 16'd0);

        // Coincident e1/e2: only the mode's own edge acts.
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("both adj", shown(), 16'h0101);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("both run", shown(), 16'h0102);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clear beats a coincident increment at 12:34.
        do_reset();
        @(negedge clk);
        adj_edges(1'b0, 12);
        adj_edges(1'b1, 34);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("preset 1234", shown(), 16'h1234);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_state("clr vs e1", 16'h0000, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_state("clr vs e2", 16'h0000, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-count while paused, then first edge after reset.
        do_reset();
        @(negedge clk);
        adj_edges(1'b0, 37);
        adj_edges(1'b1, 21);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_state("preset 3721", 16'h3721, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_state("mid reset", 16'h0000, 1'b0, 1'b0);
        clk_1hz = 1'b1;
        @(posedge clk);
        #1;
        check("first edge", shown(), 16'h0001);
        @(negedge clk);
        clk_1hz = 1'b0;
        @(negedge clk);
        check("held after edge", shown(), 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no finish, expected finish before 2 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
